// File: rtl/mult_pipe_if.sv
// mult_pipe_if: bundles the execute->mult1 operand bus, the decode source
// addresses with the hazard flag, and the write-back port of mult_pipe.
// slave = the multiplier, master = whoever drives operands and reads results.
interface mult_pipe_if;
  logic [31:0] mult1_rs1_data_i;
  logic [31:0] mult1_rs2_data_i;
  logic [4:0]  mult1_write_addr_i;
  logic        mult1_int_write_enable_i;
  logic [31:0] mult1_instruction_i;
  logic [31:0] mult1_pc_i;

  logic [4:0]  dec_rs1_addr_i;
  logic [4:0]  dec_rs2_addr_i;
  logic        mult_hazard_o;

  logic [31:0] wb_int_write_data_o;
  logic [4:0]  wb_write_addr_o;
  logic        wb_int_write_enable_o;
  logic [31:0] wb_instruction_o;
  logic [31:0] wb_pc_o;

  modport slave (
    input  mult1_rs1_data_i, mult1_rs2_data_i, mult1_write_addr_i,
           mult1_int_write_enable_i, mult1_instruction_i, mult1_pc_i,
           dec_rs1_addr_i, dec_rs2_addr_i,
    output mult_hazard_o,
           wb_int_write_data_o, wb_write_addr_o, wb_int_write_enable_o,
           wb_instruction_o, wb_pc_o
  );

  modport master (
    output mult1_rs1_data_i, mult1_rs2_data_i, mult1_write_addr_i,
           mult1_int_write_enable_i, mult1_instruction_i, mult1_pc_i,
           dec_rs1_addr_i, dec_rs2_addr_i,
    input  mult_hazard_o,
           wb_int_write_data_o, wb_write_addr_o, wb_int_write_enable_o,
           wb_instruction_o, wb_pc_o
  );
endinterface

// File: rtl/mult_pipe.sv
// mult_pipe: 4-stage RV32M multiplier (S1 extend, S2 partial products,
// S3 sum, S4 select) with global stall, flush and a RAW hazard flag over
// S1..S3. Optional feature macro: MULT_HIGH_EN enables MULH/MULHSU/MULHU;
// without it operands are unsigned and only the low word is produced.
module mult_pipe (
  input logic        clk_i,
  input logic        rsn_i,
  input logic        stall_i,
  input logic        flush_i,
  mult_pipe_if.slave bus
);
  localparam int STAGES = 4;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] instr;
    logic [31:0] pc;
  } ctl_t;

  logic [STAGES:1] vld_pipe;
  ctl_t [STAGES:1] ctl_q;
  ctl_t            ctl_in;
  logic            adv;
  logic [31:0]     res_q;
  logic            hazard;

  // Flush forces the stages to move even under stall; valid is cleared anyway.
  assign adv    = flush_i | ~stall_i;
  assign ctl_in = '{addr: bus.mult1_write_addr_i,
                    instr: bus.mult1_instruction_i,
                    pc: bus.mult1_pc_i};

`ifdef MULT_HIGH_EN
  logic [2:0]         f3_in, f3_s3;
  logic               rs1_sgn, rs2_sgn;
  logic signed [32:0] a_q, b_q;
  logic [31:0]        pp_ll_q;
  logic signed [33:0] pp_lh_q, pp_hl_q, pp_hh_q;
  logic signed [33:0] al_x, ah_x, bl_x, bh_x;
  logic [63:0]        prod_q, prod_sum;

  assign f3_in   = bus.mult1_instruction_i[14:12];
  assign f3_s3   = ctl_q[3].instr[14:12];
  assign rs1_sgn = (f3_in == 3'b001) || (f3_in == 3'b010);
  assign rs2_sgn = (f3_in == 3'b001);

  // Split 33-bit operands into an unsigned low half and a signed high 17 bits,
  // widened so every partial product is computed at its full signed width.
  assign al_x = {18'b0, a_q[15:0]};
  assign bl_x = {18'b0, b_q[15:0]};
  assign ah_x = {{17{a_q[32]}}, a_q[32:16]};
  assign bh_x = {{17{b_q[32]}}, b_q[32:16]};

  // Bits above 63 of the true 66-bit sum never reach the result, so the sum
  // is carried modulo 2^64.
  assign prod_sum = {32'b0, pp_ll_q}
                  + ({{30{pp_lh_q[33]}}, pp_lh_q} << 16)
                  + ({{30{pp_hl_q[33]}}, pp_hl_q} << 16)
                  + ({{30{pp_hh_q[33]}}, pp_hh_q} << 32);

  // Datapath stages S1..S4, advancing together with the control fields.
  always_ff @(posedge clk_i or posedge rsn_i) begin
    if (rsn_i) begin
      a_q     <= '0;
      b_q     <= '0;
      pp_ll_q <= '0;
      pp_lh_q <= '0;
      pp_hl_q <= '0;
      pp_hh_q <= '0;
      prod_q  <= '0;
      res_q   <= '0;
    end else if (adv) begin
      a_q     <= {rs1_sgn & bus.mult1_rs1_data_i[31], bus.mult1_rs1_data_i};
      b_q     <= {rs2_sgn & bus.mult1_rs2_data_i[31], bus.mult1_rs2_data_i};
      pp_ll_q <= {16'b0, a_q[15:0]} * {16'b0, b_q[15:0]};
      pp_lh_q <= al_x * bh_x;
      pp_hl_q <= ah_x * bl_x;
      pp_hh_q <= ah_x * bh_x;
      prod_q  <= prod_sum;
      case (f3_s3)
        3'b001, 3'b010, 3'b011: res_q <= prod_q[63:32];
        default:                res_q <= prod_q[31:0];
      endcase
    end
  end
`else
  logic [31:0] a_q, b_q;
  logic [31:0] pp_ll_q;
  logic [15:0] pp_lh_q, pp_hl_q;
  logic [31:0] prod_q;

  // Low-word-only datapath: the cross terms only matter in their low 16 bits
  // and the high x high term never touches bits [31:0].
  always_ff @(posedge clk_i or posedge rsn_i) begin
    if (rsn_i) begin
      a_q     <= '0;
      b_q     <= '0;
      pp_ll_q <= '0;
      pp_lh_q <= '0;
      pp_hl_q <= '0;
      prod_q  <= '0;
      res_q   <= '0;
    end else if (adv) begin
      a_q     <= bus.mult1_rs1_data_i;
      b_q     <= bus.mult1_rs2_data_i;
      pp_ll_q <= {16'b0, a_q[15:0]} * {16'b0, b_q[15:0]};
      pp_lh_q <= a_q[15:0] * b_q[31:16];
      pp_hl_q <= a_q[31:16] * b_q[15:0];
      prod_q  <= pp_ll_q + {pp_lh_q + pp_hl_q, 16'b0};
      res_q   <= prod_q;
    end
  end
`endif

  // Valid shift register: flush clears every stage, stall holds it.
  always_ff @(posedge clk_i or posedge rsn_i) begin
    if (rsn_i)         vld_pipe <= '0;
    else if (flush_i)  vld_pipe <= '0;
    else if (!stall_i) vld_pipe <= {vld_pipe[STAGES-1:1], bus.mult1_int_write_enable_i};
  end

  // Control fields ride alongside the datapath; they may load during a flush.
  always_ff @(posedge clk_i or posedge rsn_i) begin
    if (rsn_i)    ctl_q <= '0;
    else if (adv) ctl_q <= {ctl_q[STAGES-1:1], ctl_in};
  end

  // RAW hazard against S1..S3; S4 is covered by write-back forwarding.
  always_comb begin
    hazard = 1'b0;
    for (int s = 1; s < STAGES; s++)
      if (vld_pipe[s] && (ctl_q[s].addr != 5'd0) &&
          ((ctl_q[s].addr == bus.dec_rs1_addr_i) ||
           (ctl_q[s].addr == bus.dec_rs2_addr_i)))
        hazard = 1'b1;
  end

  assign bus.mult_hazard_o         = hazard;
  assign bus.wb_int_write_enable_o = vld_pipe[STAGES];
  assign bus.wb_write_addr_o       = ctl_q[STAGES].addr;
  assign bus.wb_instruction_o      = ctl_q[STAGES].instr;
  assign bus.wb_pc_o               = ctl_q[STAGES].pc;
  assign bus.wb_int_write_data_o   = res_q;
endmodule

// File: tb/tb_mult_pipe.sv
// tb_mult_pipe: randomized and directed checks of mult_pipe against a
// timeline model: the write-back port shows the op accepted four advancing
// edges ago; a flush kills everything accepted so far.
module tb_mult_pipe;
  logic clk_i = 1'b0;
  logic rsn_i, stall_i, flush_i;
  int   tests = 0;
  int   fails = 0;

  mult_pipe_if bus();

  mult_pipe dut (
    .clk_i  (clk_i),
    .rsn_i  (rsn_i),
    .stall_i(stall_i),
    .flush_i(flush_i),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] instr;
    logic [31:0] pc;
  } wb_t;

  typedef struct {
    wb_t w;
    bit  kill;
  } ent_t;

  ent_t hist[$];

  function automatic logic [31:0] ref_mul(logic [31:0] a, logic [31:0] b, logic [2:0] f3);
`ifdef MULT_HIGH_EN
    logic signed [63:0] sa, sb;
    logic [63:0]        p;
    sa = (f3 == 3'd1 || f3 == 3'd2) ? {{32{a[31]}}, a} : {32'b0, a};
    sb = (f3 == 3'd1) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = sa * sb;
    return (f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd3) ? p[63:32] : p[31:0];
`else
    return a * b;
`endif
  endfunction

  function automatic void model_reset();
    ent_t z;
    z.w    = '0;
    z.kill = 1'b0;
    hist.delete();
    repeat (4) hist.push_back(z);
  endfunction

  function automatic void model_edge();
    ent_t e;
    e.w.en    = bus.mult1_int_write_enable_i;
    e.w.addr  = bus.mult1_write_addr_i;
    e.w.data  = ref_mul(bus.mult1_rs1_data_i, bus.mult1_rs2_data_i, bus.mult1_instruction_i[14:12]);
    e.w.instr = bus.mult1_instruction_i;
    e.w.pc    = bus.mult1_pc_i;
    e.kill    = 1'b0;
    if (flush_i) begin
      foreach (hist[i]) hist[i].kill = 1'b1;
      e.kill = 1'b1;
      hist.push_back(e);
    end else if (!stall_i) begin
      hist.push_back(e);
    end
    while (hist.size() > 8) void'(hist.pop_front());
  endfunction

  function automatic wb_t exp_w();
    return hist[hist.size()-4].w;
  endfunction

  function automatic bit exp_kill();
    return hist[hist.size()-4].kill || !hist[hist.size()-4].w.en ? hist[hist.size()-4].kill : 1'b0;
  endfunction

  function automatic logic exp_haz();
    logic h;
    h = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      ent_t e;
      e = hist[hist.size()-k];
      if (!e.kill && e.w.en && e.w.addr != 5'd0 &&
          (e.w.addr == bus.dec_rs1_addr_i || e.w.addr == bus.dec_rs2_addr_i))
        h = 1'b1;
    end
    return h;
  endfunction

  function automatic wb_t dut_w();
    return {bus.wb_int_write_enable_o, bus.wb_write_addr_o, bus.wb_int_write_data_o,
            bus.wb_instruction_o, bus.wb_pc_o};
  endfunction

  // One clock edge; the model follows the DUT only while reset is low.
  task automatic cycle();
    @(posedge clk_i);
    if (!rsn_i) model_edge();
    #1;
  endtask

  task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] addr,
                          input logic we, input logic [2:0] f3);
    bus.mult1_rs1_data_i         = a;
    bus.mult1_rs2_data_i         = b;
    bus.mult1_write_addr_i       = addr;
    bus.mult1_int_write_enable_i = we;
    bus.mult1_instruction_i      = {7'b0000001, 10'($urandom), f3, 5'($urandom), 7'b0110011};
    bus.mult1_pc_i               = $urandom & 32'hFFFF_FFFC;
  endtask

  task automatic bubble();
    drive_op($urandom, $urandom, 5'($urandom), 1'b0, 3'd0);
  endtask

  task automatic idle(input int n);
    bubble();
    repeat (n) cycle();
  endtask

  task automatic test_reset();
    rsn_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    bus.dec_rs1_addr_i = 5'd3;
    bus.dec_rs2_addr_i = 5'd0;
    drive_op(32'd5, 32'd9, 5'd3, 1'b1, 3'd0);
    model_reset();
    #3;
    tests++;
    if (dut_w() !== '0 || bus.mult_hazard_o !== 1'b0) begin
      fails++; $display("FAIL reset_state got wb=%h haz=%b need all zero", dut_w(), bus.mult_hazard_o);
    end
    cycle();
    cycle();
    tests++;
    if (dut_w() !== '0 || bus.mult_hazard_o !== 1'b0) begin
      fails++; $display("FAIL reset_held got wb=%h haz=%b need all zero", dut_w(), bus.mult_hazard_o);
    end
    rsn_i = 1'b0;
    bubble();
  endtask

  task automatic test_mul();
    logic [31:0] pc, instr;
    idle(4);
    drive_op(32'd7, 32'd6, 5'd5, 1'b1, 3'b000);
    pc = bus.mult1_pc_i; instr = bus.mult1_instruction_i;
    cycle();
    bubble();
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) cycle();
      tests++;
      if (exp_kill() ? (bus.wb_int_write_enable_o !== 1'b0) : (dut_w() !== exp_w())) begin
        fails++; $display("FAIL mul_model got=%h need=%h", dut_w(), exp_w());
      end
    end
    tests++;
    if (dut_w() !== {1'b1, 5'd5, 32'd42, instr, pc}) begin
      fails++; $display("FAIL mul_7x6 got=%h need=%h", dut_w(), {1'b1, 5'd5, 32'd42, instr, pc});
    end
  endtask

  task automatic test_high();
    logic [31:0] need [3];
    logic [31:0] ra [3];
    logic [31:0] rb [3];
    logic [2:0]  f3 [3];
`ifdef MULT_HIGH_EN
    need[0] = 32'h4000_0000; need[1] = 32'hFFFF_FFFE; need[2] = 32'hFFFF_FFFF;
`else
    need[0] = 32'h0000_0000; need[1] = 32'h0000_0001; need[2] = 32'h0000_0001;
`endif
    ra[0] = 32'h8000_0000; rb[0] = 32'h8000_0000; f3[0] = 3'b001;
    ra[1] = 32'hFFFF_FFFF; rb[1] = 32'hFFFF_FFFF; f3[1] = 3'b011;
    ra[2] = 32'hFFFF_FFFF; rb[2] = 32'hFFFF_FFFF; f3[2] = 3'b010;
    idle(4);
    for (int i = 0; i < 6; i++) begin
      if (i < 3) drive_op(ra[i], rb[i], 5'(10 + i), 1'b1, f3[i]);
      else bubble();
      cycle();
      tests++;
      if (exp_kill() ? (bus.wb_int_write_enable_o !== 1'b0) : (dut_w() !== exp_w())) begin
        fails++; $display("FAIL high_model got=%h need=%h", dut_w(), exp_w());
      end
      if (i >= 3) begin
        tests++;
        if (bus.wb_int_write_enable_o !== 1'b1 || bus.wb_int_write_data_o !== need[i-3] ||
            bus.wb_write_addr_o !== 5'(7 + i)) begin
          fails++; $display("FAIL high_op%0d got data=%h en=%b addr=%0d need data=%h en=1 addr=%0d",
                            i - 3, bus.wb_int_write_data_o, bus.wb_int_write_enable_o,
                            bus.wb_write_addr_o, need[i-3], 7 + i);
        end
      end
    end
  endtask

  task automatic test_stall();
    wb_t held;
    idle(4);
    drive_op(32'd3, 32'd4, 5'd7, 1'b1, 3'b000);
    cycle();
    bubble();
    cycle();
    held    = dut_w();
    stall_i = 1'b1;
    drive_op(32'd99, 32'd99, 5'd8, 1'b1, 3'b000);
    for (int i = 0; i < 2; i++) begin
      cycle();
      tests++;
      if (dut_w() !== held || dut_w() !== exp_w()) begin
        fails++; $display("FAIL stall_hold got=%h need=%h", dut_w(), held);
      end
    end
    stall_i = 1'b0;
    bubble();
    for (int i = 0; i < 2; i++) begin
      cycle();
      tests++;
      if (exp_kill() ? (bus.wb_int_write_enable_o !== 1'b0) : (dut_w() !== exp_w())) begin
        fails++; $display("FAIL stall_model got=%h need=%h", dut_w(), exp_w());
      end
    end
    tests++;
    if (bus.wb_int_write_enable_o !== 1'b1 || bus.wb_int_write_data_o !== 32'd12 ||
        bus.wb_write_addr_o !== 5'd7) begin
      fails++; $display("FAIL stall_result got data=%0d en=%b need data=12 en=1",
                        bus.wb_int_write_data_o, bus.wb_int_write_enable_o);
    end
  endtask

  task automatic test_flush();
    idle(4);
    bus.dec_rs1_addr_i = 5'd11;
    bus.dec_rs2_addr_i = 5'd0;
    for (int i = 0; i < 3; i++) begin
      drive_op($urandom, $urandom, 5'd11, 1'b1, 3'b000);
      cycle();
    end
    tests++;
    if (bus.mult_hazard_o !== 1'b1) begin
      fails++; $display("FAIL flush_pre_hazard got=%b need=1", bus.mult_hazard_o);
    end
    drive_op($urandom, $urandom, 5'd11, 1'b1, 3'b000);
    flush_i = 1'b1;
    cycle();
    flush_i = 1'b0;
    bubble();
    tests++;
    if (bus.mult_hazard_o !== 1'b0 || exp_haz() !== 1'b0) begin
      fails++; $display("FAIL flush_hazard_drop got=%b need=0", bus.mult_hazard_o);
    end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cycle();
      tests++;
      if (bus.wb_int_write_enable_o !== 1'b0) begin
        fails++; $display("FAIL flush_wb_en cycle %0d got=%b need=0", i, bus.wb_int_write_enable_o);
      end
    end
  endtask

  task automatic test_hazard();
    int cnt;
    idle(4);
    bus.dec_rs1_addr_i = 5'd9;
    bus.dec_rs2_addr_i = 5'd0;
    drive_op($urandom, $urandom, 5'd9, 1'b1, 3'b000);
    cnt = 0;
    for (int i = 1; i <= 6; i++) begin
      cycle();
      bubble();
      if (bus.mult_hazard_o === 1'b1) cnt++;
      tests++;
      if (bus.mult_hazard_o !== exp_haz() || bus.mult_hazard_o !== (i <= 3)) begin
        fails++; $display("FAIL hazard_addr9 cycle %0d got=%b need=%b", i, bus.mult_hazard_o, i <= 3);
      end
    end
    tests++;
    if (cnt != 3) begin
      fails++; $display("FAIL hazard_count got=%0d need=3", cnt);
    end
    bus.dec_rs1_addr_i = 5'd0;
    drive_op($urandom, $urandom, 5'd0, 1'b1, 3'b000);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      bubble();
      if (bus.mult_hazard_o !== 1'b0) cnt++;
    end
    tests++;
    if (cnt != 0) begin
      fails++; $display("FAIL hazard_x0 got=%0d asserted cycles need=0", cnt);
    end
  endtask

  task automatic test_reset_mid();
    idle(4);
    bus.dec_rs1_addr_i = 5'd12;
    bus.dec_rs2_addr_i = 5'd13;
    drive_op($urandom, $urandom, 5'd12, 1'b1, 3'b000);
    cycle();
    drive_op($urandom, $urandom, 5'd13, 1'b1, 3'b000);
    cycle();
    bubble();
    #2;
    tests++;
    if (bus.mult_hazard_o !== 1'b1) begin
      fails++; $display("FAIL rstmid_pre_hazard got=%b need=1", bus.mult_hazard_o);
    end
    rsn_i = 1'b1;
    model_reset();
    #1;
    tests++;
    if (dut_w() !== '0 || bus.mult_hazard_o !== 1'b0) begin
      fails++; $display("FAIL rstmid_async got wb=%h haz=%b need all zero", dut_w(), bus.mult_hazard_o);
    end
    @(posedge clk_i);
    #1;
    rsn_i = 1'b0;
    drive_op(32'd11, 32'd13, 5'd4, 1'b1, 3'b000);
    for (int i = 1; i <= 6; i++) begin
      cycle();
      bubble();
      tests++;
      if (exp_kill() ? (bus.wb_int_write_enable_o !== 1'b0) : (dut_w() !== exp_w())) begin
        fails++; $display("FAIL rstmid_after cycle %0d got=%h need=%h", i, dut_w(), exp_w());
      end
      if (i == 4) begin
        tests++;
        if (bus.wb_int_write_enable_o !== 1'b1 || bus.wb_int_write_data_o !== 32'd143) begin
          fails++; $display("FAIL rstmid_first_op got data=%0d en=%b need data=143 en=1",
                            bus.wb_int_write_data_o, bus.wb_int_write_enable_o);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive_op($urandom, $urandom, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
               3'($urandom));
      if ($urandom_range(0, 3) == 0) bus.mult1_rs1_data_i = 32'h8000_0000 | 32'($urandom_range(0, 1));
      stall_i = ($urandom_range(0, 4) == 0);
      flush_i = ($urandom_range(0, 19) == 0);
      bus.dec_rs1_addr_i = 5'($urandom_range(0, 7));
      bus.dec_rs2_addr_i = 5'($urandom_range(0, 7));
      cycle();
      tests++;
      if (exp_kill() ? (bus.wb_int_write_enable_o !== 1'b0) : (dut_w() !== exp_w())) begin
        fails++; $display("FAIL random_wb step %0d got=%h need=%h", i, dut_w(), exp_w());
      end
      tests++;
      if (bus.mult_hazard_o !== exp_haz()) begin
        fails++; $display("FAIL random_hazard step %0d got=%b need=%b", i, bus.mult_hazard_o, exp_haz());
      end
    end
    stall_i = 1'b0;
    flush_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_high();
    test_stall();
    test_flush();
    test_hazard();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
